input_cmd_sched: RTL and testbench
==================================

INPUT_CMD_SCHED -- requirements
Module: input_cmd_sched

Interface
REQ-001 Parameter FIRE_COOLDOWN, default 8: number of TICK pulses after a granted FIRE during which further FIRE requests are rejected; legal range 1..255.
REQ-002 Parameter QDEPTH, default 4: command FIFO depth in entries; power of two, 2..16.
REQ-003 Parameter REPEAT_TICKS, default 6: TICK pulses of continuous hold before a direction auto-repeats; legal range 1..255; used only with INPUT_AUTOREPEAT_EN.
REQ-004 Reset aclr_i, asynchronous, active-high; clock CLK.
REQ-005 CLK  in  1  system clock; all state updates on the rising edge.
REQ-006 aclr_i  in  1  asynchronous active-high clear.
REQ-007 TICK  in  1  frame tick; high for exactly one CLK cycle per frame.
REQ-008 BTN_P  in  3  debounced one-cycle press pulses, with bit2 = FIRE, bit1 = RIGHT, bit0 = LEFT.
REQ-009 BTN_LVL  in  3  debounced held levels, same bit order as BTN_P.
REQ-010 CMD_READY  in  1  consumer accepts the head command.
REQ-011 CMD_VALID  out  1  FIFO non-empty.
REQ-012 CMD  out  2  head command, encoded 01 = LEFT, 10 = RIGHT, 11 = FIRE; 00 whenever CMD_VALID is 0.
REQ-013 FIRE_BUSY  out  1  fire cooldown active.
REQ-014 DROP  out  1  one-cycle pulse when a request is discarded.

Function
REQ-015 The block SHALL hold one sticky pending bit per button; a BTN_P pulse sets the bit at the next edge; a pulse on an already-pending button merges without DROP.
REQ-016 The arbiter SHALL grant at most one pending request per cycle, with fixed priority FIRE > LEFT > RIGHT; a grant pushes the command into the FIFO and clears that pending bit at the same edge.
REQ-017 The arbiter SHALL make no grant while the FIFO is full and not popping in the same cycle; pending bits are held, not dropped.
REQ-018 A simultaneous push and pop SHALL be legal at any occupancy, including full; occupancy stays unchanged.
REQ-019 The FIFO SHALL pop when CMD_VALID and CMD_READY are both high; CMD, CMD_VALID and occupancy are registered outputs.
REQ-020 Latency: a BTN_P pulse in cycle n with an empty FIFO and no higher-priority pending request SHALL give CMD_VALID = 1 with the matching CMD in cycle n+2.
REQ-021 The cooldown FSM SHALL have two states:
- FIRE_RDY: FIRE_BUSY = 0; a FIRE grant loads the counter with FIRE_COOLDOWN and moves to FIRE_COOL.
- FIRE_COOL: FIRE_BUSY = 1; the counter decrements on TICK; on reaching 0 the FSM returns to FIRE_RDY at that edge.
REQ-022 A FIRE_P pulse arriving while in FIRE_COOL SHALL be discarded, with a DROP pulse in the following cycle; a FIRE already pending when cooldown starts cannot exist, because FIRE is granted first.
REQ-023 LEFT and RIGHT pending together SHALL both be queued, LEFT first, over consecutive grant cycles.
REQ-024 TICK during a FIRE grant cycle SHALL NOT decrement the newly loaded counter.

Reset
REQ-025 aclr_i SHALL immediately clear all pending bits, the FIFO pointers and occupancy, the cooldown counter and the repeat counters, and force the FSM to FIRE_RDY.
REQ-026 While aclr_i is high, all outputs SHALL be 0: CMD_VALID = 0, CMD = 00, FIRE_BUSY = 0, DROP = 0.
REQ-027 Commands queued when reset asserts mid-operation SHALL be lost; the first valid command after release requires a new BTN_P pulse.

Configuration
REQ-028 With INPUT_AUTOREPEAT_EN defined, the block SHALL keep a per-direction counter for LEFT and RIGHT:
- The counter clears when its BTN_LVL bit is 0 or its BTN_P pulse occurs.
- The counter increments on TICK while the level is held.
- On reaching REPEAT_TICKS, the counter sets that direction's pending bit and clears itself.
REQ-029 Without INPUT_AUTOREPEAT_EN, the repeat counters SHALL be absent, BTN_LVL SHALL be ignored, and only BTN_P creates requests.

Verification
REQ-030 Reset, then BTN_P = 001 in cycle 5 with CMD_READY = 1 -> CMD = 01 and CMD_VALID = 1 in cycle 7 only.
REQ-031 BTN_P = 111 in one cycle, CMD_READY = 1 -> CMD sequence 11, 01, 10 on consecutive cycles; FIRE_BUSY = 1 after the FIRE grant.
REQ-032 FIRE granted, then FIRE_P after 3 TICKs -> DROP pulse and no queued FIRE; after the 8th TICK FIRE_BUSY = 0, and the next FIRE_P is queued.
REQ-033 CMD_READY = 0, six LEFT/RIGHT alternating pulses with QDEPTH = 4 -> 4 entries queued, excess held pending, no DROP; raising CMD_READY drains all in order.
REQ-034 Full FIFO with CMD_READY = 1 and a pending request -> push and pop in the same cycle, CMD_VALID stays 1.
REQ-035 INPUT_AUTOREPEAT_EN defined, BTN_LVL[1] held for 13 TICKs after an initial press -> exactly 3 RIGHT commands; reset asserted mid-hold -> CMD_VALID = 0 immediately.

Source files
------------

// File: rtl/input_cmd_sched.sv
// Button command scheduler: sticky pending requests, FIRE > LEFT > RIGHT arbiter, command FIFO, fire cooldown.
// Optional INPUT_AUTOREPEAT_EN adds hold-to-repeat for LEFT/RIGHT driven by BTN_LVL and TICK.
//
// state     | meaning
// FIRE_RDY  | FIRE may be granted; a grant loads the cooldown counter
// FIRE_COOL | cooldown running; counts down on TICK, new FIRE presses are dropped
module input_cmd_sched #(
    parameter int FIRE_COOLDOWN = 8,
    parameter int QDEPTH        = 4,
    parameter int REPEAT_TICKS  = 6
) (
    input  logic       CLK,
    input  logic       aclr_i,
    input  logic       TICK,
    input  logic [2:0] BTN_P,
    input  logic [2:0] BTN_LVL,
    input  logic       CMD_READY,
    output logic       CMD_VALID,
    output logic [1:0] CMD,
    output logic       FIRE_BUSY,
    output logic       DROP
);

    localparam int PW = $clog2(QDEPTH);

    typedef enum logic {FIRE_RDY = 1'b0, FIRE_COOL = 1'b1} fire_state_t;

    fire_state_t state, state_n;
    logic [7:0]  cool_cnt, cool_cnt_n;
    logic [2:0]  pend, pend_n;
    logic [1:0]  rep_set;
    logic [1:0]  mem [QDEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count;
    logic        drop_q;
    logic        pop, full, can_push, push;
    logic        gnt_fire, gnt_left, gnt_right, fire_drop;
    logic [1:0]  push_cmd;

`ifdef INPUT_AUTOREPEAT_EN
    logic [7:0] rep_cnt [2];
    logic       unused_lvl;
    assign unused_lvl = BTN_LVL[2];

    // Direction i repeats when the held level sees its REPEAT_TICKS-th TICK.
    always_comb begin
        rep_set = '0;
        for (int i = 0; i < 2; i++)
            rep_set[i] = BTN_LVL[i] & ~BTN_P[i] & TICK & (rep_cnt[i] == 8'(REPEAT_TICKS - 1));
    end

    always_ff @(posedge CLK or posedge aclr_i) begin
        if (aclr_i) begin
            rep_cnt[0] <= '0;
            rep_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!BTN_LVL[i] || BTN_P[i])
                    rep_cnt[i] <= '0;
                else if (rep_set[i])
                    rep_cnt[i] <= '0;
                else if (TICK)
                    rep_cnt[i] <= rep_cnt[i] + 8'd1;
            end
        end
    end
`else
    logic unused_lvl;
    assign unused_lvl = ^BTN_LVL;
    assign rep_set    = '0;
`endif

    assign CMD_VALID = (count != '0);
    assign CMD       = CMD_VALID ? mem[rd_ptr] : 2'b00;
    assign FIRE_BUSY = (state == FIRE_COOL);
    assign DROP      = drop_q;

    assign pop       = CMD_VALID & CMD_READY;
    assign full      = (count == (PW+1)'(QDEPTH));
    assign can_push  = ~full | pop;
    assign gnt_fire  = can_push & pend[2];
    assign gnt_left  = can_push & pend[0] & ~pend[2];
    assign gnt_right = can_push & pend[1] & ~pend[2] & ~pend[0];
    assign push      = gnt_fire | gnt_left | gnt_right;
    assign push_cmd  = gnt_fire ? 2'b11 : (gnt_left ? 2'b01 : 2'b10);
    // A press landing on the grant edge would queue a second FIRE inside the cooldown.
    assign fire_drop = BTN_P[2] & ((state == FIRE_COOL) | gnt_fire);

    always_comb begin
        pend_n[0] = (pend[0] & ~gnt_left)  | BTN_P[0] | rep_set[0];
        pend_n[1] = (pend[1] & ~gnt_right) | BTN_P[1] | rep_set[1];
        pend_n[2] = (pend[2] & ~gnt_fire)  | (BTN_P[2] & ~fire_drop);
    end

    always_comb begin
        state_n    = state;
        cool_cnt_n = cool_cnt;
        case (state)
            FIRE_RDY: begin
                if (gnt_fire) begin
                    cool_cnt_n = 8'(FIRE_COOLDOWN);
                    state_n    = FIRE_COOL;
                end
            end
            FIRE_COOL: begin
                if (TICK) begin
                    cool_cnt_n = cool_cnt - 8'd1;
                    if (cool_cnt <= 8'd1) begin
                        cool_cnt_n = '0;
                        state_n    = FIRE_RDY;
                    end
                end
            end
            default: state_n = FIRE_RDY;
        endcase
    end

    always_ff @(posedge CLK or posedge aclr_i) begin
        if (aclr_i) begin
            state    <= FIRE_RDY;
            cool_cnt <= '0;
            pend     <= '0;
            drop_q   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_n;
            cool_cnt <= cool_cnt_n;
            pend     <= pend_n;
            drop_q   <= fire_drop;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= push_cmd;
    end

endmodule

// File: tb/tb_input_cmd_sched.sv
// Scoreboard bench for input_cmd_sched: expected commands are queued with each press and popped on accept.
module tb_input_cmd_sched;

    logic       CLK = 1'b0;
    logic       aclr_i, TICK, CMD_READY;
    logic [2:0] BTN_P, BTN_LVL;
    logic       CMD_VALID, FIRE_BUSY, DROP;
    logic [1:0] CMD;

    int         vectors = 0;
    int         miscompares = 0;
    logic [1:0] exp_q [$];
    logic [1:0] sb_exp;

    input_cmd_sched dut (
        .CLK(CLK), .aclr_i(aclr_i), .TICK(TICK), .BTN_P(BTN_P), .BTN_LVL(BTN_LVL),
        .CMD_READY(CMD_READY), .CMD_VALID(CMD_VALID), .CMD(CMD),
        .FIRE_BUSY(FIRE_BUSY), .DROP(DROP)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (!aclr_i && CMD_VALID && CMD_READY) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_cmd: got CMD %b, required no command", CMD);
            end else begin
                sb_exp = exp_q.pop_front();
                if (CMD !== sb_exp) begin
                    miscompares++;
                    $display("FAIL sb_cmd: got CMD %b, required %b", CMD, sb_exp);
                end
            end
        end
        if (CMD_VALID === 1'b0) begin
            vectors++;
            if (CMD !== 2'b00) begin
                miscompares++;
                $display("FAIL cmd_idle: got CMD %b, required 00", CMD);
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse(input logic [2:0] p);
        BTN_P = p;
        cyc();
        BTN_P = 3'b000;
    endtask

    task automatic tick();
        TICK = 1'b1;
        cyc();
        TICK = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++)
            cyc();
    endtask

    task automatic test_reset();
        aclr_i = 1'b1; TICK = 1'b0; BTN_P = 3'b000; BTN_LVL = 3'b000; CMD_READY = 1'b1;
        #2;
        vectors++;
        if ({CMD_VALID, CMD, FIRE_BUSY, DROP} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_outs: got %b, required 00000", {CMD_VALID, CMD, FIRE_BUSY, DROP});
        end
        BTN_P = 3'b111;
        repeat (3) cyc();
        vectors++;
        if ({CMD_VALID, CMD, FIRE_BUSY, DROP} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_held: got %b, required 00000", {CMD_VALID, CMD, FIRE_BUSY, DROP});
        end
        BTN_P = 3'b000;
        aclr_i = 1'b0;
    endtask

    task automatic test_latency();
        repeat (4) cyc();
        exp_q.push_back(2'b01);
        pulse(3'b001);
        @(negedge CLK);
        vectors++;
        if (CMD_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL lat_n1: got CMD_VALID %b, required 0", CMD_VALID);
        end
        @(negedge CLK);
        vectors++;
        if ({CMD_VALID, CMD} !== 3'b101) begin
            miscompares++;
            $display("FAIL lat_n2: got VALID/CMD %b, required 101", {CMD_VALID, CMD});
        end
        @(negedge CLK);
        vectors++;
        if (CMD_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL lat_n3: got CMD_VALID %b, required 0", CMD_VALID);
        end
    endtask

    task automatic test_priority();
        exp_q.push_back(2'b11);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        pulse(3'b111);
        @(negedge CLK);
        @(negedge CLK);
        vectors++;
        if ({CMD_VALID, CMD, FIRE_BUSY} !== 4'b1111) begin
            miscompares++;
            $display("FAIL prio_fire: got VALID/CMD/BUSY %b, required 1111", {CMD_VALID, CMD, FIRE_BUSY});
        end
        @(negedge CLK);
        vectors++;
        if ({CMD_VALID, CMD} !== 3'b101) begin
            miscompares++;
            $display("FAIL prio_left: got VALID/CMD %b, required 101", {CMD_VALID, CMD});
        end
        @(negedge CLK);
        vectors++;
        if ({CMD_VALID, CMD} !== 3'b110) begin
            miscompares++;
            $display("FAIL prio_right: got VALID/CMD %b, required 110", {CMD_VALID, CMD});
        end
        repeat (8) tick();
        vectors++;
        if (FIRE_BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_cool_end: got FIRE_BUSY %b, required 0", FIRE_BUSY);
        end
    endtask

    task automatic test_cooldown();
        exp_q.push_back(2'b11);
        pulse(3'b100);
        cyc();
        cyc();
        repeat (3) tick();
        pulse(3'b100);
        @(negedge CLK);
        vectors++;
        if ({DROP, FIRE_BUSY} !== 2'b11) begin
            miscompares++;
            $display("FAIL cool_drop: got DROP/BUSY %b, required 11", {DROP, FIRE_BUSY});
        end
        @(negedge CLK);
        vectors++;
        if (DROP !== 1'b0) begin
            miscompares++;
            $display("FAIL cool_drop_width: got DROP %b, required 0", DROP);
        end
        repeat (4) tick();
        vectors++;
        if (FIRE_BUSY !== 1'b1) begin
            miscompares++;
            $display("FAIL cool_tick7: got FIRE_BUSY %b, required 1", FIRE_BUSY);
        end
        tick();
        vectors++;
        if (FIRE_BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL cool_tick8: got FIRE_BUSY %b, required 0", FIRE_BUSY);
        end
        exp_q.push_back(2'b11);
        pulse(3'b100);
        wait_drain();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL cool_refire: got %0d outstanding, required 0", exp_q.size());
        end
        repeat (8) tick();
    endtask

    task automatic test_full();
        CMD_READY = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
            pulse((i % 2 == 0) ? 3'b001 : 3'b010);
            @(negedge CLK);
            vectors++;
            if (DROP !== 1'b0) begin
                miscompares++;
                $display("FAIL full_nodrop%0d: got DROP %b, required 0", i, DROP);
            end
        end
        cyc();
        cyc();
        @(negedge CLK);
        vectors++;
        if ({CMD_VALID, CMD, DROP} !== 4'b1010) begin
            miscompares++;
            $display("FAIL full_head: got VALID/CMD/DROP %b, required 1010", {CMD_VALID, CMD, DROP});
        end
        cyc();
        CMD_READY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            vectors++;
            if (CMD_VALID !== 1'b1) begin
                miscompares++;
                $display("FAIL full_drain%0d: got CMD_VALID %b, required 1", i, CMD_VALID);
            end
        end
        @(negedge CLK);
        vectors++;
        if (CMD_VALID !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL full_empty: got VALID %b outstanding %0d, required 0 and 0", CMD_VALID, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        CMD_READY = 1'b0;
        pulse(3'b001);
        pulse(3'b010);
        repeat (3) cyc();
        @(negedge CLK);
        vectors++;
        if (CMD_VALID !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_pre: got CMD_VALID %b, required 1", CMD_VALID);
        end
        #1 aclr_i = 1'b1;
        #1;
        vectors++;
        if ({CMD_VALID, CMD, FIRE_BUSY, DROP} !== 5'b0) begin
            miscompares++;
            $display("FAIL rst_mid_now: got %b, required 00000", {CMD_VALID, CMD, FIRE_BUSY, DROP});
        end
        exp_q.delete();
        cyc();
        cyc();
        aclr_i = 1'b0;
        repeat (3) cyc();
        vectors++;
        if (CMD_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_lost: got CMD_VALID %b, required 0", CMD_VALID);
        end
        CMD_READY = 1'b1;
        exp_q.push_back(2'b10);
        pulse(3'b010);
        wait_drain();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rst_mid_new: got %0d outstanding, required 0", exp_q.size());
        end
    endtask

`ifdef INPUT_AUTOREPEAT_EN
    task automatic test_autorepeat();
        CMD_READY = 1'b1;
        BTN_LVL = 3'b010;
        repeat (3) exp_q.push_back(2'b10);
        pulse(3'b010);
        repeat (13) tick();
        repeat (3) cyc();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rep_count: got %0d outstanding, required 0", exp_q.size());
        end
        CMD_READY = 1'b0;
        repeat (6) tick();
        @(negedge CLK);
        vectors++;
        if (CMD_VALID !== 1'b1) begin
            miscompares++;
            $display("FAIL rep_queued: got CMD_VALID %b, required 1", CMD_VALID);
        end
        #1 aclr_i = 1'b1;
        #1;
        vectors++;
        if (CMD_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL rep_reset: got CMD_VALID %b, required 0", CMD_VALID);
        end
        exp_q.delete();
        BTN_LVL = 3'b000;
        cyc();
        aclr_i = 1'b0;
        CMD_READY = 1'b1;
        cyc();
    endtask
`else
    task automatic test_lvl_ignored();
        CMD_READY = 1'b0;
        BTN_LVL = 3'b011;
        repeat (14) tick();
        @(negedge CLK);
        vectors++;
        if (CMD_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL lvl_ignored: got CMD_VALID %b, required 0", CMD_VALID);
        end
        BTN_LVL = 3'b000;
        CMD_READY = 1'b1;
        cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_priority();
        test_cooldown();
        test_full();
`ifdef INPUT_AUTOREPEAT_EN
        test_autorepeat();
`else
        test_lvl_ignored();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
